// File: rtl/cntr_datapath_pkg.sv
// Shared counter command encodings and snapshot handshake states.
package cntr_operations;

    typedef enum logic [1:0] {
        cntr_op_state_1 = 2'd1,
        cntr_op_state_2 = 2'd2,
        cntr_op_state_3 = 2'd3
    } cntr_operations_t;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_ACK  = 1'b1
    } snap_state_t;

    localparam int unsigned CNT_MAX_DEFAULT = 127;

endpackage

// File: rtl/cntr_datapath_snapshot_if.sv
// 4-phase req/ack snapshot port: captures {wrap_cnt, cnt} on request and
// holds it until the next accepted request.
module cntr_snapshot_if
    import cntr_operations::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned WRAP_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    snap_req,
    input  logic [CNT_W-1:0]        cnt,
    input  logic [WRAP_W-1:0]       wrap_cnt,
    output logic                    snap_ack,
    output logic [CNT_W+WRAP_W-1:0] snap_data
);

    snap_state_t                 state_q, state_d;
    logic [CNT_W+WRAP_W-1:0]     snap_data_q, snap_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SNAP_IDLE;
            snap_data_q <= '0;
        end else begin
            state_q     <= state_d;
            snap_data_q <= snap_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_data_d = snap_data_q;
        case (state_q)
            SNAP_IDLE: begin
                if (snap_req) begin
                    snap_data_d = {wrap_cnt, cnt};
                    state_d     = SNAP_ACK;
                end
            end
            SNAP_ACK: begin
                if (!snap_req) state_d = SNAP_IDLE;
            end
            default: state_d = SNAP_IDLE;
        endcase
    end

    always_comb begin
        snap_ack  = (state_q == SNAP_ACK);
        snap_data = snap_data_q;
    end

endmodule

// File: rtl/cntr_datapath.sv
// Counter datapath: executes per-cycle commands on the count register and
// tracks wrap events, sticky error flags and the snapshot readout port.
module cntr_datapath
    import cntr_operations::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT,
    parameter int unsigned WRAP_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  cntr_operations_t        operation,
    output logic [CNT_W-1:0]        cnt_out_t,
    output logic [WRAP_W-1:0]       wrap_cnt,
    output logic                    wrap_valid,
    input  logic                    wrap_ready,
    output logic                    wrap_lost,
    output logic                    proto_err,
    input  logic                    snap_req,
    output logic                    snap_ack,
    output logic [CNT_W+WRAP_W-1:0] snap_data
);

    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              wrap_valid_q, wrap_valid_d;
    logic              wrap_lost_q, wrap_lost_d;
    logic              proto_err_q, proto_err_d;
    logic              wrap_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            wrap_cnt_q   <= '0;
            wrap_valid_q <= 1'b0;
            wrap_lost_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            wrap_cnt_q   <= wrap_cnt_d;
            wrap_valid_q <= wrap_valid_d;
            wrap_lost_q  <= wrap_lost_d;
            proto_err_q  <= proto_err_d;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        wrap_cnt_d  = wrap_cnt_q;
        proto_err_d = proto_err_q;
        wrap_evt    = 1'b0;
        case (operation)
            cntr_op_state_1: begin
                cnt_d      = '0;
                wrap_cnt_d = wrap_cnt_q + 1'b1;
                wrap_evt   = 1'b1;
            end
            cntr_op_state_2: begin
                // Incrementing past terminal count is a controller error, not a wrap.
                if (cnt_q >= CNT_MAX_V) begin
                    cnt_d       = '0;
                    proto_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        wrap_valid_d = wrap_valid_q;
        wrap_lost_d  = wrap_lost_q;
        if (wrap_evt) begin
            wrap_valid_d = 1'b1;
            if (wrap_valid_q && !wrap_ready) wrap_lost_d = 1'b1;
        end else if (wrap_valid_q && wrap_ready) begin
            wrap_valid_d = 1'b0;
        end
    end

    cntr_snapshot_if #(
        .CNT_W  (CNT_W),
        .WRAP_W (WRAP_W)
    ) u_snap (
        .clk       (clk),
        .rst_n     (rst),
        .snap_req  (snap_req),
        .cnt       (cnt_q),
        .wrap_cnt  (wrap_cnt_q),
        .snap_ack  (snap_ack),
        .snap_data (snap_data)
    );

    always_comb begin
        cnt_out_t  = cnt_q;
        wrap_cnt   = wrap_cnt_q;
        wrap_valid = wrap_valid_q;
        wrap_lost  = wrap_lost_q;
        proto_err  = proto_err_q;
    end

endmodule

// File: tb/tb_cntr_datapath.sv
// Scoreboard bench for cntr_datapath: stimulus pushes predicted outputs,
// a negedge monitor pops and compares them.
module tb_cntr_datapath;
    import cntr_operations::*;

    localparam int OW = 32 + 16 + 4 + 48;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    cntr_operations_t operation = cntr_op_state_3;
    logic             wrap_ready = 1'b0;
    logic             snap_req = 1'b0;
    logic [31:0]      cnt_out_t;
    logic [15:0]      wrap_cnt;
    logic             wrap_valid, wrap_lost, proto_err, snap_ack;
    logic [47:0]      snap_data;

    int errors = 0;
    int checks = 0;

    logic [OW-1:0] exp_q[$];
    string         tag_q[$];

    logic [31:0] m_cnt;
    logic [15:0] m_wrap;
    logic        m_valid, m_lost, m_proto, m_ack;
    logic [47:0] m_data;

    cntr_datapath #(.CNT_W(32), .CNT_MAX(127), .WRAP_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .operation  (operation),
        .cnt_out_t  (cnt_out_t),
        .wrap_cnt   (wrap_cnt),
        .wrap_valid (wrap_valid),
        .wrap_ready (wrap_ready),
        .wrap_lost  (wrap_lost),
        .proto_err  (proto_err),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .snap_data  (snap_data)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] dut_vec();
        return {cnt_out_t, wrap_cnt, wrap_valid, wrap_lost, proto_err, snap_ack, snap_data};
    endfunction

    function automatic logic [OW-1:0] model_vec();
        return {m_cnt, m_wrap, m_valid, m_lost, m_proto, m_ack, m_data};
    endfunction

    function automatic void check(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_cnt = '0; m_wrap = '0; m_valid = 1'b0; m_lost = 1'b0;
        m_proto = 1'b0; m_ack = 1'b0; m_data = '0;
    endfunction

    // Predicts register state after one posedge with the current inputs.
    function automatic void model_edge(input cntr_operations_t op, input logic rdy, input logic req);
        logic evt = 1'b0;
        logic [31:0] pc = m_cnt;
        logic [15:0] pw = m_wrap;
        if (!m_ack && req) begin m_data = {pw, pc}; m_ack = 1'b1; end
        else if (m_ack && !req) m_ack = 1'b0;
        if (op == cntr_op_state_1) begin
            m_cnt = 0; m_wrap = pw + 16'd1; evt = 1'b1;
        end else if (op == cntr_op_state_2) begin
            if (pc >= 32'd127) begin m_cnt = 0; m_proto = 1'b1; end
            else m_cnt = pc + 32'd1;
        end
        if (evt) begin
            if (m_valid && !rdy) m_lost = 1'b1;
            m_valid = 1'b1;
        end else if (m_valid && rdy) m_valid = 1'b0;
    endfunction

    task automatic step(input cntr_operations_t op, input logic rdy, input logic req, input string tag);
        operation = op; wrap_ready = rdy; snap_req = req;
        @(posedge clk);
        model_edge(op, rdy, req);
        exp_q.push_back(model_vec());
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        model_reset();
        #1 check("reset_outputs", dut_vec(), '0);
        @(negedge clk);
        operation = cntr_op_state_3; wrap_ready = 1'b0; snap_req = 1'b0;
        rst = 1'b1;
    endtask

    // Monitor: every cycle the DUT outputs are live, compare against the oldest prediction.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), dut_vec(), exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        reset_dut();

        // 1: count to terminal, then wrap and handshake
        for (int unsigned i = 0; i < 127; i++) step(cntr_op_state_2, 1'b0, 1'b0, "t1_inc");
        check("t1_cnt127", {68'd0, cnt_out_t}, {68'd0, 32'd127});
        step(cntr_op_state_1, 1'b0, 1'b0, "t1_wrap");
        check("t1_after_wrap", {68'd0, cnt_out_t, wrap_cnt, wrap_valid},
              {68'd0, 32'd0, 16'd1, 1'b1});
        step(cntr_op_state_3, 1'b0, 1'b0, "t1_pending");
        step(cntr_op_state_3, 1'b1, 1'b0, "t1_accept");
        check("t1_valid_clear", {99'd0, wrap_valid}, '0);
        step(cntr_op_state_3, 1'b1, 1'b0, "t1_ready_idle");

        // 2: hold at 42, with one unlisted encoding mixed in
        for (int unsigned i = 0; i < 42; i++) step(cntr_op_state_2, 1'b0, 1'b0, "t2_inc");
        for (int unsigned i = 0; i < 9; i++) step(cntr_op_state_3, 1'b0, 1'b0, "t2_hold");
        step(cntr_operations_t'(2'd0), 1'b0, 1'b0, "t2_unknown_op");
        check("t2_hold42", {65'd0, cnt_out_t, wrap_lost, proto_err, wrap_valid},
              {65'd0, 32'd42, 3'b000});

        // 3a: two wraps without handshake -> lost
        reset_dut();
        step(cntr_op_state_1, 1'b0, 1'b0, "t3a_wrap1");
        step(cntr_op_state_3, 1'b0, 1'b0, "t3a_gap");
        step(cntr_op_state_1, 1'b0, 1'b0, "t3a_wrap2");
        check("t3a_lost", {81'd0, wrap_cnt, wrap_valid, wrap_lost, proto_err},
              {81'd0, 16'd2, 3'b110});
        // 3b: second wrap coincides with handshake -> no loss
        reset_dut();
        step(cntr_op_state_1, 1'b0, 1'b0, "t3b_wrap1");
        step(cntr_op_state_3, 1'b0, 1'b0, "t3b_gap");
        step(cntr_op_state_1, 1'b1, 1'b0, "t3b_wrap2_ready");
        check("t3b_no_lost", {81'd0, wrap_cnt, wrap_valid, wrap_lost, proto_err},
              {81'd0, 16'd2, 3'b100});
        step(cntr_op_state_3, 1'b1, 1'b0, "t3b_accept");

        // 4: increment at terminal count
        for (int unsigned i = 0; i < 127; i++) step(cntr_op_state_2, 1'b0, 1'b0, "t4_inc");
        step(cntr_op_state_2, 1'b0, 1'b0, "t4_overflow");
        check("t4_proto", {49'd0, cnt_out_t, wrap_cnt, wrap_valid, proto_err},
              {49'd0, 32'd0, 16'd2, 1'b0, 1'b1});
        step(cntr_op_state_2, 1'b0, 1'b0, "t4_resume");

        // 5: snapshot at cnt=5, wrap_cnt=3
        reset_dut();
        for (int unsigned i = 0; i < 3; i++) step(cntr_op_state_1, 1'b1, 1'b0, "t5_wrap");
        for (int unsigned i = 0; i < 5; i++) step(cntr_op_state_2, 1'b0, 1'b0, "t5_inc");
        step(cntr_op_state_2, 1'b0, 1'b1, "t5_req");
        check("t5_ack_data", {51'd0, snap_ack, snap_data}, {51'd0, 1'b1, 16'd3, 32'd5});
        step(cntr_op_state_3, 1'b0, 1'b1, "t5_req_hold");
        step(cntr_op_state_2, 1'b0, 1'b1, "t5_req_hold2");
        step(cntr_op_state_3, 1'b0, 1'b0, "t5_req_drop");
        check("t5_ack_low", {51'd0, snap_ack, snap_data}, {51'd0, 1'b0, 16'd3, 32'd5});
        step(cntr_op_state_2, 1'b0, 1'b0, "t5_idle");
        step(cntr_op_state_2, 1'b0, 1'b1, "t5_req2");
        step(cntr_op_state_3, 1'b0, 1'b0, "t5_drop2");

        // 6: async reset mid-cycle with ack and wrap_valid high
        step(cntr_op_state_2, 1'b0, 1'b0, "t6_inc");
        step(cntr_op_state_1, 1'b0, 1'b1, "t6_wrap_req");
        check("t6_pre_reset", {98'd0, snap_ack, wrap_valid}, {98'd0, 2'b11});
        #2 rst = 1'b0;
        model_reset();
        #1 check("t6_async_reset", dut_vec(), '0);
        @(negedge clk);
        operation = cntr_op_state_3; wrap_ready = 1'b0; snap_req = 1'b0;
        rst = 1'b1;
        for (int unsigned i = 0; i < 3; i++) step(cntr_op_state_2, 1'b0, 1'b0, "t6_resume");
        check("t6_cnt3", {68'd0, cnt_out_t}, {68'd0, 32'd3});

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
